// File: rtl/puf_rng_pkg.sv
// Shared types and constants for the PUF RNG nibble packer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package puf_rng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FAIL    = 2'd2
    } state_t;

    localparam int NIB_PER_WORD = 8;
    localparam int NIB_W        = 4;
    localparam int WORD_W       = 32;

endpackage

// File: rtl/puf_rng_fifo.sv
// Synchronous word FIFO with push/pop/flush and occupancy count.
// Latency: a push is visible at the head on the cycle after the write edge.
// Backpressure: push is dropped when full unless a pop frees a slot that cycle; pop on empty is ignored.
module puf_rng_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    // Storage array: no reset needed, contents are qualified by count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/puf_rng_packer.sv
// Health-tests PUF RNG nibbles, packs 8 into a 32-bit word and buffers words for the consumer.
// Latency: 8th accepted nibble edge -> word_valid_o the following cycle.
// Backpressure: es_rng_req_o drops when the FIFO would be full; strobes without an active request are dropped.
module puf_rng_packer
    import puf_rng_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int RCT_THRESH = 6
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic                          clear_i,
    input  logic [3:0]                    rng4bit_i,
    input  logic                          rng4bit_done_i,
    input  logic                          rng_mode_i,
    output logic                          es_rng_req_o,
    output logic                          word_valid_o,
    output logic [31:0]                   word_o,
    input  logic                          word_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   word_count_o,
    output logic                          health_fail_o,
    output logic                          busy_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]       THRESH_C = 4'(RCT_THRESH);

    state_t              state_q;
    state_t              state_d;
    logic [2:0]          nib_cnt_q;
    logic [3:0]          rep_cnt_q;
    logic [3:0]          prev_nib_q;
    logic [WORD_W-1:0]   word_q;
    logic                health_q;
    logic                req_q;
    logic                req_d;

    logic                accept;
    logic                same_nib;
    logic [3:0]          rep_new;
    logic                trip;
    logic                push;
    logic                flush;
    logic                pop_eff;
    logic [WORD_W-1:0]   push_dat;
    logic [WORD_W-1:0]   head_dat;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_d;
    logic                fifo_full;
    logic                fifo_empty;

    // A held request implies we are in COLLECT, so no state term is needed here.
    assign accept   = rng4bit_done_i && req_q && rng_mode_i;
    assign same_nib = (rng4bit_i == prev_nib_q) && (rep_cnt_q != 4'd0);
    assign rep_new  = same_nib ? (rep_cnt_q + 4'd1) : 4'd1;
    assign trip     = accept && (rep_new == THRESH_C);
    // The 8th nibble is merged straight into the pushed word; it never lands in word_q.
    assign push     = accept && !trip && !clear_i && (nib_cnt_q == 3'd7);
    assign push_dat = {rng4bit_i, word_q[27:0]};
    assign flush    = clear_i || trip;
    assign pop_eff  = word_ready_i && !fifo_empty;

    // Next state; clear overrides everything including a same-cycle trip.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (enable_i) state_d = ST_COLLECT;
            ST_COLLECT: begin
                if (trip)           state_d = ST_FAIL;
                else if (!enable_i) state_d = ST_IDLE;
            end
            ST_FAIL:    state_d = ST_FAIL;
            default:    state_d = ST_IDLE;
        endcase
        if (clear_i) state_d = ST_IDLE;
    end

    // Predict next FIFO occupancy so the request can be registered without a bubble.
    always_comb begin
        cnt_d = cnt;
        if (flush) begin
            cnt_d = '0;
        end else if (push && !pop_eff) begin
            cnt_d = cnt + CNT_W'(1);
        end else if (!push && pop_eff) begin
            cnt_d = cnt - CNT_W'(1);
        end
        req_d = (state_d == ST_COLLECT) && rng_mode_i && (cnt_d < DEPTH_C);
    end

    // State and request registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    // Packing and repetition-count health test.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            nib_cnt_q  <= 3'd0;
            rep_cnt_q  <= 4'd0;
            prev_nib_q <= 4'd0;
            word_q     <= '0;
            health_q   <= 1'b0;
        end else if (clear_i) begin
            nib_cnt_q <= 3'd0;
            rep_cnt_q <= 4'd0;
            word_q    <= '0;
            health_q  <= 1'b0;
        end else begin
            if (accept) begin
                rep_cnt_q  <= rep_new;
                prev_nib_q <= rng4bit_i;
            end
            if (trip) begin
                health_q  <= 1'b1;
                nib_cnt_q <= 3'd0;
                word_q    <= '0;
            end else if ((state_q == ST_COLLECT) && !enable_i) begin
                nib_cnt_q <= 3'd0;
                word_q    <= '0;
            end else if (accept) begin
                nib_cnt_q <= nib_cnt_q + 3'd1;
                if (nib_cnt_q == 3'd7) begin
                    word_q <= '0;
                end else begin
                    word_q[{nib_cnt_q, 2'b00} +: NIB_W] <= rng4bit_i;
                end
            end
        end
    end

    puf_rng_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .flush    (flush),
        .push     (push),
        .push_dat (push_dat),
        .pop      (word_ready_i),
        .head_dat (head_dat),
        .count    (cnt),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign es_rng_req_o  = req_q;
    assign health_fail_o = health_q;
    assign busy_o        = (state_q == ST_COLLECT);
    assign word_valid_o  = !fifo_empty;
    assign word_o        = fifo_empty ? '0 : head_dat;
    assign word_count_o  = cnt;

    // Full is implied by the request gating; kept for observability only.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_puf_rng_packer.sv
// Directed bench for puf_rng_packer with hand-computed expectations.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises FIFO-full request drop, simultaneous push/pop and disable/clear paths.
module tb_puf_rng_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        clear;
    logic [3:0]  rng4bit;
    logic        rng4bit_done;
    logic        rng_mode;
    logic        es_rng_req;
    logic        word_valid;
    logic [31:0] word;
    logic        word_ready;
    logic [2:0]  word_count;
    logic        health_fail;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    puf_rng_packer #(
        .FIFO_DEPTH (4),
        .RCT_THRESH (6)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .clear_i        (clear),
        .rng4bit_i      (rng4bit),
        .rng4bit_done_i (rng4bit_done),
        .rng_mode_i     (rng_mode),
        .es_rng_req_o   (es_rng_req),
        .word_valid_o   (word_valid),
        .word_o         (word),
        .word_ready_i   (word_ready),
        .word_count_o   (word_count),
        .health_fail_o  (health_fail),
        .busy_o         (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_nib(input logic [3:0] n);
        rng4bit      = n;
        rng4bit_done = 1'b1;
        tick();
        rng4bit_done = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic pop_last);
        for (int i = 0; i < 8; i++) begin
            if (i == 7 && pop_last) word_ready = 1'b1;
            send_nib(w[4*i +: 4]);
            word_ready = 1'b0;
        end
    endtask

    task automatic pop_one();
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},    {31'd0, es_rng_req},  32'd0);
        check({tag, "_valid"},  {31'd0, word_valid},  32'd0);
        check({tag, "_word"},   word,                 32'd0);
        check({tag, "_count"},  {29'd0, word_count},  32'd0);
        check({tag, "_health"}, {31'd0, health_fail}, 32'd0);
        check({tag, "_busy"},   {31'd0, busy},        32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        clear        = 1'b0;
        rng4bit      = 4'd0;
        rng4bit_done = 1'b0;
        rng_mode     = 1'b0;
        word_ready   = 1'b0;
        tick();
        tick();
        check_all_zero("reset");

        // First word 1..8 packed LSB first.
        rst      = 1'b0;
        enable   = 1'b1;
        rng_mode = 1'b1;
        tick();
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_req", {31'd0, es_rng_req}, 32'd1);
        for (int i = 1; i <= 7; i++) send_nib(4'(i));
        check("w0_not_yet_valid", {31'd0, word_valid}, 32'd0);
        send_nib(4'd8);
        check("w0_valid", {31'd0, word_valid}, 32'd1);
        check("w0_word", word, 32'h87654321);
        check("w0_count", {29'd0, word_count}, 32'd1);

        // Fill FIFO to depth with consumer stalled.
        send_word(32'h0FEDCBA9, 1'b0);
        send_word(32'h89ABCDEF, 1'b0);
        send_word(32'h13572468, 1'b0);
        check("full_count", {29'd0, word_count}, 32'd4);
        check("full_req", {31'd0, es_rng_req}, 32'd0);
        send_nib(4'd5);
        check("full_strobe_ignored", {29'd0, word_count}, 32'd4);
        check("full_head", word, 32'h87654321);
        pop_one();
        check("pop_req_back", {31'd0, es_rng_req}, 32'd1);
        check("pop_count", {29'd0, word_count}, 32'd3);
        send_word(32'hCAFEBABE, 1'b0);
        check("refill_count", {29'd0, word_count}, 32'd4);
        check("drain_head0", word, 32'h0FEDCBA9);
        pop_one();
        check("drain_head1", word, 32'h89ABCDEF);
        pop_one();
        check("drain_head2", word, 32'h13572468);
        pop_one();
        check("drain_head3", word, 32'hCAFEBABE);
        pop_one();
        check("drain_empty_valid", {31'd0, word_valid}, 32'd0);
        check("drain_empty_count", {29'd0, word_count}, 32'd0);

        // Repetition-count trip: 1,2,3 then six 5s; the 5th five completes a word.
        send_nib(4'd1);
        send_nib(4'd2);
        send_nib(4'd3);
        for (int i = 0; i < 5; i++) send_nib(4'd5);
        check("rct_pre_health", {31'd0, health_fail}, 32'd0);
        check("rct_pre_count", {29'd0, word_count}, 32'd1);
        check("rct_pre_word", word, 32'h55555321);
        send_nib(4'd5);
        check("rct_health", {31'd0, health_fail}, 32'd1);
        check("rct_flushed_count", {29'd0, word_count}, 32'd0);
        check("rct_flushed_valid", {31'd0, word_valid}, 32'd0);
        check("rct_req", {31'd0, es_rng_req}, 32'd0);
        check("rct_busy", {31'd0, busy}, 32'd0);
        tick();
        check("fail_sticky", {31'd0, health_fail}, 32'd1);
        check("fail_ignores_enable", {31'd0, busy}, 32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_health", {31'd0, health_fail}, 32'd0);
        check("clear_idle", {31'd0, busy}, 32'd0);
        check("clear_req", {31'd0, es_rng_req}, 32'd0);
        tick();
        check("clear_collect", {31'd0, busy}, 32'd1);
        check("clear_collect_req", {31'd0, es_rng_req}, 32'd1);

        // Disable mid-word discards the partial word, keeps stored words.
        send_word(32'hDEADBEEF, 1'b0);
        send_nib(4'd1);
        send_nib(4'd2);
        send_nib(4'd3);
        send_nib(4'd4);
        enable = 1'b0;
        tick();
        check("dis_busy", {31'd0, busy}, 32'd0);
        check("dis_req", {31'd0, es_rng_req}, 32'd0);
        check("dis_count", {29'd0, word_count}, 32'd1);
        enable = 1'b1;
        tick();
        check("reen_busy", {31'd0, busy}, 32'd1);
        send_word(32'h2468ACE0, 1'b0);
        check("reen_count", {29'd0, word_count}, 32'd2);
        check("reen_old_head", word, 32'hDEADBEEF);
        pop_one();
        check("reen_new_word", word, 32'h2468ACE0);

        // rng_mode low: request drops and strobes are ignored.
        rng_mode = 1'b0;
        tick();
        check("mode_req", {31'd0, es_rng_req}, 32'd0);
        send_nib(4'd7);
        send_nib(4'd7);
        send_nib(4'd7);
        check("mode_count", {29'd0, word_count}, 32'd1);
        rng_mode = 1'b1;
        tick();
        check("mode_req_back", {31'd0, es_rng_req}, 32'd1);

        // Simultaneous push and pop at count 2.
        send_word(32'h0F1E2D3C, 1'b0);
        check("pp_pre_count", {29'd0, word_count}, 32'd2);
        send_word(32'h5A5A5A5A, 1'b1);
        check("pp_count", {29'd0, word_count}, 32'd2);
        check("pp_head", word, 32'h0F1E2D3C);

        // Asynchronous reset in the middle of a word.
        for (int i = 1; i <= 5; i++) send_nib(4'(i));
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_req", {31'd0, es_rng_req}, 32'd1);
        send_word(32'h76543218, 1'b0);
        check("post_rst_valid", {31'd0, word_valid}, 32'd1);
        check("post_rst_word", word, 32'h76543218);
        check("post_rst_count", {29'd0, word_count}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/puf_rng_packer.md
Name: puf_rng_packer

Overview:
- Downstream consumer of the PUF core's RNG outputs (rng4bit, rng4bit_done, rng_mode).
- Drives the PUF's es_rng_req.
- Runs a repetition-count health test on each 4-bit sample, packs 8 accepted nibbles into a 32-bit word, and buffers words in a small FIFO.
- Words are presented to the entropy-source consumer over a valid/ready interface.

Parameters:
- FIFO_DEPTH, 4, number of 32-bit words buffered (power of two, >=2).
- RCT_THRESH, 6, consecutive identical nibbles that trip the health test (2..15).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- enable_i  in  1  block enable (from control register)
- clear_i  in  1  single-cycle pulse; clears health failure and flushes all state
- rng4bit_i  in  4  nibble from PUF core
- rng4bit_done_i  in  1  nibble strobe from PUF core
- rng_mode_i  in  1  PUF core is in RNG mode
- es_rng_req_o  out  1  request to PUF core for nibbles
- word_valid_o  out  1  FIFO head word valid
- word_o  out  32  FIFO head word
- word_ready_i  in  1  consumer accepts head word
- word_count_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- health_fail_o  out  1  sticky repetition-count failure
- busy_o  out  1  state is COLLECT

Behaviour:
- Reset: all outputs 0; state IDLE; nibble_cnt=0; rep_cnt=0; prev_nib=0; FIFO empty.

State machine (IDLE, COLLECT, FAIL):
- IDLE -> COLLECT when enable_i=1 and clear_i=0.
- COLLECT -> IDLE when enable_i=0. The partial word and nibble_cnt are discarded; FIFO contents are retained.
- COLLECT -> FAIL when the health test trips.
- FAIL -> IDLE only on clear_i. enable_i is ignored while in FAIL.
- clear_i from any state: next state IDLE, FIFO flushed, partial word dropped, rep_cnt=0, health_fail_o=0. clear_i has priority over every simultaneous event, including a failure detected in the same cycle.

es_rng_req_o:
- Registered. Equals 1 when next state is COLLECT, rng_mode_i=1, and next FIFO occupancy < FIFO_DEPTH.

Nibble acceptance:
- A nibble is accepted in a cycle where rng4bit_done_i=1, es_rng_req_o=1 (current registered value), and rng_mode_i=1.
- Strobes outside this condition are dropped silently.

Packing:
- LSB-first: the k-th accepted nibble (k=0..7) goes to bits [4k+3:4k].
- nibble_cnt is 3 bits and wraps 7->0.
- On the 8th accepted nibble, the full word is written into the FIFO on the same clock edge. The FIFO is never full at that point, because req is deasserted at full.

Health test (evaluated per accepted nibble):
- If nibble==prev_nib and rep_cnt!=0: rep_cnt+1; otherwise rep_cnt=1. prev_nib takes the nibble.
- When the new rep_cnt would equal RCT_THRESH:
  - health_fail_o=1 on the next edge;
  - the nibble is not packed;
  - the partial word is dropped;
  - the FIFO is flushed (word_valid_o=0, word_count_o=0 next cycle);
  - state goes to FAIL.

FIFO:
- Pop when word_valid_o & word_ready_i.
- Push and pop in the same cycle leave the count unchanged.
- word_o is the head word and is stable while valid and not popped.
- Pop while empty has no effect.
- Read/write pointers wrap modulo FIFO_DEPTH.
- Latency: 8th nibble edge -> word_valid_o=1 the following cycle.

Decomposition:
- puf_rng_pkg holds:
  - state enum typedef (IDLE/COLLECT/FAIL);
  - NIB_PER_WORD=8;
  - WORD_W=32.
- One sub-module, puf_rng_fifo: a synchronous FIFO with width and depth parameters, push/pop/flush, and count/full/empty outputs.

Test Plan:
- Reset release, enable_i=1, rng_mode_i=1; feed nibbles 1,2,3,4,5,6,7,8 -> word_o=32'h87654321, word_valid_o=1 one cycle after the 8th strobe, word_count_o=1.
- word_ready_i=0 and FIFO_DEPTH=4 words filled -> es_rng_req_o=0, word_count_o=4. A further done strobe is ignored. One pop -> req=1 again the next cycle.
- Feed 5,5,5,5,5,5 after 3 distinct nibbles -> health_fail_o=1 after the 6th 5, FIFO empty, req=0. clear_i -> health_fail_o=0, state IDLE, then COLLECT.
- 4 nibbles accepted, then enable_i=0, then re-enable; feed 8 nibbles A..H -> the first word contains only the post-enable nibbles. Previously stored words are intact.
- rng_mode_i=0 with done strobes -> nothing accepted and req=0. Simultaneous push and pop at count=2 -> count stays 2.
- Assert rst_i mid-word (nibble_cnt=5) -> all outputs 0 immediately (asynchronous). After release, the next word is packed from nibble 0.
